// File: rtl/ipd_ctrl_sat_pkg.sv
// Shared types and helpers for the I-PD servo controller: FSM encoding,
// output clamp and sign extension into the accumulator domain.
package ipd_ctrl_sat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MP   = 3'd1,
    ST_MD   = 3'd2,
    ST_MI   = 3'd3,
    ST_SUM  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  localparam int unsigned XW = 64;

  // Sign-extend the low 'width' bits of v to the full 64-bit helper width.
  function automatic logic signed [XW-1:0] sext64(input logic [XW-1:0] v,
                                                  input int unsigned width);
    logic signed [XW-1:0] t;
    t = v << (XW - width);
    return t >>> (XW - width);
  endfunction

  function automatic logic signed [XW-1:0] clamp64(input logic signed [XW-1:0] v,
                                                   input logic signed [XW-1:0] lo,
                                                   input logic signed [XW-1:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ipd_ctrl_sat_mul.sv
// Shared combinational signed multiplier; operand selection lives in the parent FSM.
module ipd_mul_shared #(
  parameter int W = 16
) (
  input  logic signed [W:0]   a,
  input  logic signed [W-1:0] b,
  output logic signed [2*W:0] p
);

  assign p = a * b;

endmodule

// File: rtl/ipd_ctrl_sat.sv
// I-PD servo controller with runtime gains, output clamp and integrator
// anti-windup; one shared multiplier sequenced over a fixed FSM.
//
// state | meaning
// IDLE  | waiting for Rx_En, captures inputs on request
// MP    | R_P  <= Kp*Pot
// MD    | R_D  <= Kd*(Pot - Pot_prev)
// MI    | R_Ie <= Ki*(Ref - Pot)
// SUM   | R_U  <= I + R_Ie - R_P - R_D
// OUT   | clamp/shift to Yk, Done, commit integrator and Pot_prev
module ipd_ctrl_sat
  import ipd_ctrl_sat_pkg::*;
#(
  parameter int     W     = 16,
  parameter int     FRAC  = 8,
  parameter int     ACC_W = 2*W+4,
  parameter longint U_MAX = (64'sd1 <<< (W-1)) - 64'sd1,
  parameter longint U_MIN = -(64'sd1 <<< (W-1))
) (
  input  logic                Clk_G,
  input  logic                Rst_G,
  input  logic                Rx_En,
  input  logic                Clr_I,
  input  logic signed [W-1:0] Pot,
  input  logic signed [W-1:0] Ref,
  input  logic signed [W-1:0] Kp,
  input  logic signed [W-1:0] Ki,
  input  logic signed [W-1:0] Kd,
  output logic signed [W-1:0] Yk,
  output logic                Done,
  output logic                Busy,
  output logic                Sat,
  output logic                Miss
);

  state_t state, state_nxt;

  logic signed [W-1:0]     pot_s, ref_s, kp_s, ki_s, kd_s, pot_prev;
  logic signed [ACC_W-1:0] integ, r_p, r_d, r_ie, r_u;

  logic signed [W:0]       mul_a;
  logic signed [W-1:0]     mul_b;
  logic signed [2*W:0]     mul_p;
  logic signed [ACC_W-1:0] prod_acc;

  logic signed [W:0]       d_pot, e_ref;
  logic signed [ACC_W-1:0] u_sh;
  logic signed [63:0]      u_wide;
  logic signed [W-1:0]     u_out;
  logic                    sat_hi, sat_lo;

  logic signed [ACC_W:0]   i_sum;
  logic signed [ACC_W-1:0] i_sat;
  logic                    i_hold;

  ipd_mul_shared #(.W(W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign d_pot = {pot_s[W-1], pot_s} - {pot_prev[W-1], pot_prev};
  assign e_ref = {ref_s[W-1], ref_s} - {pot_s[W-1], pot_s};

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      ST_MP: begin
        mul_a = {pot_s[W-1], pot_s};
        mul_b = kp_s;
      end
      ST_MD: begin
        mul_a = d_pot;
        mul_b = kd_s;
      end
      ST_MI: begin
        mul_a = e_ref;
        mul_b = ki_s;
      end
      default: ;
    endcase
  end

  assign prod_acc = ACC_W'(sext64(64'($unsigned(mul_p)), 2*W+1));

  // Output path: arithmetic shift out of the gain fraction, then clamp.
  assign u_sh   = r_u >>> FRAC;
  assign u_wide = 64'(u_sh);
  assign sat_hi = u_wide > U_MAX;
  assign sat_lo = u_wide < U_MIN;
  assign u_out  = W'(clamp64(u_wide, U_MIN, U_MAX));

  // Integrator candidate saturates to the accumulator range instead of wrapping.
  assign i_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(r_ie);

  always_comb begin
    i_sat = i_sum[ACC_W-1:0];
    if (i_sum[ACC_W] != i_sum[ACC_W-1])
      i_sat = i_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign i_hold = (sat_hi && !r_ie[ACC_W-1] && (r_ie != '0)) ||
                  (sat_lo &&  r_ie[ACC_W-1]);

  always_comb begin
    state_nxt = state;
    if (Clr_I) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (Rx_En) state_nxt = ST_MP;
        ST_MP:   state_nxt = ST_MD;
        ST_MD:   state_nxt = ST_MI;
        ST_MI:   state_nxt = ST_SUM;
        ST_SUM:  state_nxt = ST_OUT;
        ST_OUT:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_G or negedge Rst_G) begin
    if (!Rst_G) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign Busy = (state != ST_IDLE);

  always_ff @(posedge Clk_G or negedge Rst_G) begin
    if (!Rst_G) begin
      pot_s    <= '0;
      ref_s    <= '0;
      kp_s     <= '0;
      ki_s     <= '0;
      kd_s     <= '0;
      pot_prev <= '0;
      integ    <= '0;
      r_p      <= '0;
      r_d      <= '0;
      r_ie     <= '0;
      r_u      <= '0;
      Yk       <= '0;
      Sat      <= 1'b0;
      Done     <= 1'b0;
      Miss     <= 1'b0;
    end else begin
      Done <= 1'b0;
      Miss <= 1'b0;
      if (Clr_I) begin
        integ    <= '0;
        pot_prev <= '0;
      end else begin
        if (state != ST_IDLE) Miss <= Rx_En;
        case (state)
          ST_IDLE: begin
            if (Rx_En) begin
              pot_s <= Pot;
              ref_s <= Ref;
              kp_s  <= Kp;
              ki_s  <= Ki;
              kd_s  <= Kd;
            end
          end
          ST_MP:  r_p  <= prod_acc;
          ST_MD:  r_d  <= prod_acc;
          ST_MI:  r_ie <= prod_acc;
          ST_SUM: r_u  <= integ + r_ie - r_p - r_d;
          ST_OUT: begin
            Yk       <= u_out;
            Sat      <= sat_hi | sat_lo;
            Done     <= 1'b1;
            pot_prev <= pot_s;
            if (!i_hold) integ <= i_sat;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipd_ctrl_sat.sv
// Directed self-checking bench for ipd_ctrl_sat (W=16, FRAC=8).
module tb_ipd_ctrl_sat;

  logic               Clk_G = 1'b0;
  logic               Rst_G;
  logic               Rx_En, Clr_I;
  logic signed [15:0] Pot, Ref, Kp, Ki, Kd;
  logic signed [15:0] Yk;
  logic               Done, Busy, Sat, Miss;

  int n_cmp  = 0;
  int n_fail = 0;

  ipd_ctrl_sat #(.W(16), .FRAC(8)) dut (
    .Clk_G (Clk_G),
    .Rst_G (Rst_G),
    .Rx_En (Rx_En),
    .Clr_I (Clr_I),
    .Pot   (Pot),
    .Ref   (Ref),
    .Kp    (Kp),
    .Ki    (Ki),
    .Kd    (Kd),
    .Yk    (Yk),
    .Done  (Done),
    .Busy  (Busy),
    .Sat   (Sat),
    .Miss  (Miss)
  );

  always #5 Clk_G = ~Clk_G;

  task automatic clr_pulse();
    @(negedge Clk_G); Clr_I = 1'b1;
    @(negedge Clk_G); Clr_I = 1'b0;
  endtask

  task automatic set_in(input int pot_v, ref_v, kp_v, ki_v, kd_v);
    Pot = 16'(pot_v); Ref = 16'(ref_v); Kp = 16'(kp_v); Ki = 16'(ki_v); Kd = 16'(kd_v);
  endtask

  // One full update: checks Done timing, Busy length, Yk and Sat.
  task automatic run_sample(input int pot_v, ref_v, kp_v, ki_v, kd_v,
                            input int exp_yk, input logic exp_sat, input string nm);
    int busy_cnt, done_cnt, done_at;
    logic signed [15:0] yk_c;
    logic sat_c;
    logic signed [15:0] exp16;
    busy_cnt = 0; done_cnt = 0; done_at = -1; yk_c = '0; sat_c = 1'b0;
    exp16 = 16'(exp_yk);
    @(negedge Clk_G);
    set_in(pot_v, ref_v, kp_v, ki_v, kd_v);
    Rx_En = 1'b1;
    @(posedge Clk_G); #1;
    Rx_En = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (Busy) busy_cnt++;
      if (Done) begin done_cnt++; done_at = i; yk_c = Yk; sat_c = Sat; end
      @(posedge Clk_G); #1;
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_count got %0d want 1", nm, done_cnt); end
    n_cmp++; if (done_at !== 5) begin n_fail++; $display("FAIL %s done_latency got %0d want 5", nm, done_at); end
    n_cmp++; if (busy_cnt !== 5) begin n_fail++; $display("FAIL %s busy_cycles got %0d want 5", nm, busy_cnt); end
    n_cmp++; if (yk_c !== exp16) begin n_fail++; $display("FAIL %s yk got %0d want %0d", nm, yk_c, exp16); end
    n_cmp++; if (sat_c !== exp_sat) begin n_fail++; $display("FAIL %s sat got %0b want %0b", nm, sat_c, exp_sat); end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (Yk !== 16'sd0) begin n_fail++; $display("FAIL reset_yk got %0d want 0", Yk); end
    n_cmp++; if ({Done, Busy, Sat, Miss} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {Done, Busy, Sat, Miss}); end
    @(negedge Clk_G); Rst_G = 1'b1;
  endtask

  task automatic test_proportional();
    clr_pulse();
    run_sample(100, 0, 256, 0, 0, -100, 1'b0, "prop");
  endtask

  task automatic test_integral();
    clr_pulse();
    run_sample(0, 200, 0, 128, 0, 100, 1'b0, "integ_1");
    run_sample(0, 200, 0, 128, 0, 200, 1'b0, "integ_2");
    run_sample(0, 200, 0, 128, 0, 300, 1'b0, "integ_3");
  endtask

  task automatic test_derivative();
    clr_pulse();
    run_sample(0,  0, 0, 0, 512,   0, 1'b0, "deriv_1");
    run_sample(10, 0, 0, 0, 512, -20, 1'b0, "deriv_2");
    run_sample(10, 0, 0, 0, 512,   0, 1'b0, "deriv_3");
  endtask

  task automatic test_antiwindup();
    clr_pulse();
    run_sample(0, 32767, 0, 32767, 0, 32767, 1'b1, "sat_hi");
    run_sample(0, 0,     0, 32767, 0, 0,     1'b0, "windup_held");
  endtask

  task automatic test_miss();
    int done_cnt, done_at, miss_cnt, miss_at;
    logic signed [15:0] yk_c;
    done_cnt = 0; done_at = -1; miss_cnt = 0; miss_at = -1; yk_c = '0;
    clr_pulse();
    @(negedge Clk_G);
    set_in(100, 0, 256, 0, 0);
    Rx_En = 1'b1;
    @(posedge Clk_G); #1;
    Rx_En = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (Miss) begin miss_cnt++; miss_at = i; end
      if (Done) begin done_cnt++; done_at = i; yk_c = Yk; end
      if (i == 1) begin Rx_En = 1'b1; Pot = 16'sd50; Kp = 16'sd512; end
      if (i == 2) Rx_En = 1'b0;
      @(posedge Clk_G); #1;
    end
    n_cmp++; if (miss_cnt !== 1) begin n_fail++; $display("FAIL miss_count got %0d want 1", miss_cnt); end
    n_cmp++; if (miss_at !== 2) begin n_fail++; $display("FAIL miss_cycle got %0d want 2", miss_at); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL miss_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_at !== 5) begin n_fail++; $display("FAIL miss_done_latency got %0d want 5", done_at); end
    n_cmp++; if (yk_c !== -16'sd100) begin n_fail++; $display("FAIL miss_yk got %0d want -100", yk_c); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    clr_pulse();
    @(negedge Clk_G);
    set_in(40, 0, 256, 0, 0);
    Rx_En = 1'b1;
    @(posedge Clk_G); #1;
    Rx_En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (Done) done_cnt++;
      @(posedge Clk_G); #1;
    end
    Rst_G = 1'b0;
    #1;
    n_cmp++; if (Yk !== 16'sd0) begin n_fail++; $display("FAIL rstmid_yk got %0d want 0", Yk); end
    n_cmp++; if ({Done, Busy, Sat, Miss} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags got %b want 0000", {Done, Busy, Sat, Miss}); end
    @(negedge Clk_G); Rst_G = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk_G); #1;
      if (Done) done_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_done got %0d want 0", done_cnt); end
    n_cmp++; if (Yk !== 16'sd0) begin n_fail++; $display("FAIL rstmid_yk_after got %0d want 0", Yk); end
  endtask

  task automatic test_clear();
    int done_cnt;
    logic busy_after;
    done_cnt = 0; busy_after = 1'b1;
    test_integral();
    clr_pulse();
    run_sample(0, 200, 0, 128, 0, 100, 1'b0, "clr_restart");
    @(negedge Clk_G);
    set_in(0, 200, 0, 128, 0);
    Rx_En = 1'b1;
    @(posedge Clk_G); #1;
    Rx_En = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (Done) done_cnt++;
      if (i == 1) Clr_I = 1'b1;
      if (i == 2) begin Clr_I = 1'b0; busy_after = Busy; end
      @(posedge Clk_G); #1;
    end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL clr_abort_done got %0d want 0", done_cnt); end
    n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL clr_abort_busy got %0b want 0", busy_after); end
    n_cmp++; if (Yk !== 16'sd100) begin n_fail++; $display("FAIL clr_abort_yk got %0d want 100", Yk); end
    run_sample(0, 200, 0, 128, 0, 100, 1'b0, "clr_after_abort");
  endtask

  initial begin
    Rst_G = 1'b0; Rx_En = 1'b0; Clr_I = 1'b0;
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_antiwindup();
    test_miss();
    test_reset_mid();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ipd_ctrl_sat.md
Name: ipd_ctrl_sat

Overview:
- Parametrised I-PD servo controller with runtime gains, output saturation and integrator anti-windup.
- Sits between the position sensor interface (Pot), the setpoint source (Ref) and the PWM driver (Yk). Each Rx_En pulse triggers one control update.
- Uses one shared signed multiplier, time-multiplexed over a fixed FSM sequence.
- Control law:
  - P = Kp*Pot
  - D = Kd*(Pot - Pot_prev)
  - I += Ki*(Ref - Pot)
  - u = (I - P - D) >>> FRAC

Parameters:
W, 16, data width of Pot, Ref, gains and Yk (signed).
FRAC, 8, fractional bits of gains (Q(W-FRAC).FRAC).
ACC_W, 2*W+4, integrator/sum width (signed).
U_MAX, 2**(W-1)-1, upper output clamp.
U_MIN, -(2**(W-1)), lower output clamp.

Ports:
Clk_G  in  1  system clock, rising edge.
Rst_G  in  1  asynchronous, active-low reset.
Rx_En  in  1  sample-request strobe.
Clr_I  in  1  synchronous clear of integrator and Pot_prev.
Pot    in  W  signed plant position.
Ref    in  W  signed setpoint.
Kp     in  W  signed proportional gain.
Ki     in  W  signed integral gain.
Kd     in  W  signed derivative gain.
Yk     out W  signed saturated controller output.
Done   out 1  one-cycle pulse: Yk updated.
Busy   out 1  high while computing.
Sat    out 1  Yk was clamped on last update.
Miss   out 1  one-cycle pulse: Rx_En dropped because Busy.

Behaviour:
- Reset (Rst_G=0, async):
  - FSM goes to IDLE.
  - Yk, Done, Busy, Sat, Miss, integrator, Pot_prev and all pipeline registers go to 0.
  - Reset mid-computation discards the update; no Done pulse.
- FSM states and edges:
  - IDLE: on the edge where Rx_En=1, capture Pot_s, Ref_s, Kp_s, Ki_s, Kd_s → MP.
  - MP (edge1): R_P <= Kp_s*Pot_s → MD.
  - MD (edge2): R_D <= Kd_s*(Pot_s - Pot_prev) → MI.
  - MI (edge3): R_Ie <= Ki_s*(Ref_s - Pot_s) → SUM.
  - SUM (edge4): R_U <= I + R_Ie - R_P - R_D, computed at ACC_W → OUT.
  - OUT (edge5) → IDLE. On this edge:
    - Yk <= clamp(R_U >>> FRAC, U_MIN, U_MAX)
    - Sat <= clamped
    - Done <= 1 for one cycle
    - Pot_prev <= Pot_s
    - integrator commit as below
- Latency: Yk/Done valid exactly 5 clocks after the Rx_En sampling edge. Throughput: one update per 6 clocks.
- Busy is high in MP, MD, MI, SUM and OUT, and low in IDLE.
- Rx_En in any non-IDLE state is ignored; Miss pulses 1 cycle; inputs are not re-captured.
- Inputs are sampled only at the IDLE capture edge. Gain or Pot changes during Busy do not affect the update in flight.
- Arithmetic:
  - Differences (Pot-Pot_prev, Ref-Pot) are W+1 bits signed.
  - Shared multiplier is (W+1)x(W) → 2W+1 signed, sign-extended to ACC_W.
  - Shift is arithmetic.
- Anti-windup at OUT:
  - I_new = I + R_Ie, saturated to the ACC_W range.
  - I_new is not committed (I holds) when the output saturated high and R_Ie>0, or saturated low and R_Ie<0.
- Clr_I=1 on any edge:
  - I <= 0 and Pot_prev <= 0.
  - If not IDLE, the computation is aborted to IDLE with no Done; Yk holds.
  - Clr_I has priority over Rx_En.
- Yk holds its value between updates.

Decomposition:
- Shared package: FSM state encoding (IDLE, MP, MD, MI, SUM, OUT), the clamp function, and the ACC_W sign-extension helper.
- One sub-module, ipd_mul_shared: registered-free signed (W+1)xW multiplier. Operand muxing is done by the FSM in the parent.

Test Plan:
W=16, FRAC=8 for all scenarios.
1. Kp=256, Ki=0, Kd=0, Pot=100, Ref=0, Rx_En pulse → 5 clocks later Done=1, Yk=-100, Sat=0; Busy high for 5 cycles.
2. Integral: Kp=Kd=0, Ki=128, Ref=200, Pot=0, three samples → Yk=100, 200, 300.
3. Derivative: Kd=512, Kp=Ki=0, Pot=0 then 10 then 10 → Yk=0, -20, 0.
4. Saturation/anti-windup: Ki=32767, Ref=32767, Pot=0 → Yk=32767, Sat=1, integrator stays 0. Next sample with Ref=0, Pot=0 → Yk=0, Sat=0.
5. Rx_En asserted 2 clocks after the first → Miss pulse, single Done, result equal to single-sample value. Rst_G=0 at the SUM state → all outputs 0, no Done.
6. After scenario 2, Clr_I pulse, then sample Ref=200 → Yk=100 (integrator restarted). Clr_I during MD → no Done, Yk unchanged.
